// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared helpers for the register-array FIFO.
//   addr_w(depth)        : pointer width needed to address 'depth' entries
//   cnt_w(depth)         : occupancy counter width able to hold 0..depth
//   next_ptr(ptr, depth) : wrap-around pointer increment
//
// The wrap compares against depth-1 rather than relying on natural
// binary roll-over, so depths that are not a power of two still work.
package fifo_pkg;

  // Width of a read/write pointer for a FIFO with 'depth' entries.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Width of the occupancy counter; it must represent 'depth' itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a pointer by one, returning to zero after the last entry.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/reg_fifo_mem.sv
// reg_fifo_mem
// WIDTH x DEPTH register array used as FIFO storage.
//   clk   : write clock
//   we    : write enable, writes wdata into entry waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous)
//   rdata : contents of entry raddr, combinational
//
// The array is deliberately not reset: its contents are only meaningful
// once the FIFO control logic has written them.
module reg_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write port. No reset, so this maps onto plain
  // enable flops.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port, giving the FIFO its fall-through behaviour.
  assign rdata = mem[raddr];

endmodule : reg_fifo_mem

// File: rtl/reg_fifo.sv
// reg_fifo
// Synchronous first-word-fall-through FIFO built on a register array.
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous reset, active low
//   wr_en     : write request
//   wr_data   : word to write
//   rd_en     : read (pop) request
//   rd_data   : head-of-queue word, valid whenever empty is 0
//   full      : count equals DEPTH
//   empty     : count equals 0
//   count     : number of stored words
//   overflow  : one-cycle pulse after a write attempted while full
//   underflow : one-cycle pulse after a read attempted while empty
//
// The head entry is read combinationally from the array, so a word
// written into an empty FIFO is visible on rd_data the cycle after the
// write edge, together with empty dropping.
module reg_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full_s;
  logic empty_s;
  logic wr_accept;
  logic rd_accept;
  logic mem_we;

  // Status flags come straight from the registered count, so they change
  // in the same cycle as the count and reflect the state before the edge
  // when used in the accept decisions below.
  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign empty_s = (count_q == '0);

  // Accept decisions. A full FIFO refuses the write even when a pop
  // happens on the same edge, and an empty FIFO refuses the read even
  // when a push happens on the same edge.
  always_comb begin
    wr_accept = wr_en && !full_s;
    rd_accept = rd_en && !empty_s;
  end

  // Next-state logic for pointers, occupancy and the error pulses.
  // Rejected requests leave pointers and storage untouched and only
  // raise the matching error pulse for one cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en && !wr_accept;
    underflow_d = rd_en && !rd_accept;

    if (wr_accept) begin
      wr_ptr_d = ADDR_W'(next_ptr(32'(wr_ptr_q), DEPTH));
    end

    if (rd_accept) begin
      rd_ptr_d = ADDR_W'(next_ptr(32'(rd_ptr_q), DEPTH));
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers. Reset wins over any request on the same edge and
  // clears everything except the storage array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Gate the array write with reset so a request during reset leaves
  // storage as it was.
  assign mem_we = wr_accept && rst;

  reg_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule : reg_fifo

// File: tb/tb_reg_fifo.sv
// tb_reg_fifo
// Bench for reg_fifo. Instance A uses DEPTH=4 for the directed and random
// scenarios; instance B uses DEPTH=3 to exercise non-power-of-two wrap.
// The reference for randomized traffic is a plain queue of words.
module tb_reg_fifo;

  logic       clk = 1'b0;

  logic       rst_a, wr_en_a, rd_en_a;
  logic [7:0] wr_data_a, rd_data_a;
  logic       full_a, empty_a, overflow_a, underflow_a;
  logic [2:0] count_a;

  logic       rst_b, wr_en_b, rd_en_b;
  logic [7:0] wr_data_b, rd_data_b;
  logic       full_b, empty_b, overflow_b, underflow_b;
  logic [1:0] count_b;

  int vectors     = 0;
  int miscompares = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  reg_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .wr_en     (wr_en_a),
    .wr_data   (wr_data_a),
    .rd_en     (rd_en_a),
    .rd_data   (rd_data_a),
    .full      (full_a),
    .empty     (empty_a),
    .count     (count_a),
    .overflow  (overflow_a),
    .underflow (underflow_a)
  );

  reg_fifo #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .wr_en     (wr_en_b),
    .wr_data   (wr_data_b),
    .rd_en     (rd_en_b),
    .rd_data   (rd_data_b),
    .full      (full_b),
    .empty     (empty_b),
    .count     (count_b),
    .overflow  (overflow_b),
    .underflow (underflow_b)
  );

  // Apply one set of requests to instance A across one rising edge and
  // return at the following falling edge, where outputs are sampled.
  task automatic tick_a(input logic w, input logic r, input logic [7:0] d);
    wr_en_a   = w;
    rd_en_a   = r;
    wr_data_a = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_b(input logic w, input logic r, input logic [7:0] d);
    wr_en_b   = w;
    rd_en_b   = r;
    wr_data_b = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset held for five cycles: flags and count must be in their idle
  // values on every one of those cycles and after release.
  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    wr_en_b = 1'b0; rd_en_b = 1'b0; wr_data_b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick_a(1'b0, 1'b0, 8'h00);
      vectors++;
      if ({empty_a, full_a, count_a, overflow_a, underflow_a} !== 7'b1000000) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: got e=%b f=%b c=%0d o=%b u=%b want e=1 f=0 c=0 o=0 u=0",
                 i, empty_a, full_a, count_a, overflow_a, underflow_a);
      end
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick_a(1'b0, 1'b0, 8'h00);
    vectors++;
    if ({empty_a, full_a, count_a, overflow_a, underflow_a} !== 7'b1000000) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got e=%b f=%b c=%0d o=%b u=%b want e=1 f=0 c=0 o=0 u=0",
               empty_a, full_a, count_a, overflow_a, underflow_a);
    end
    vectors++;
    if ({empty_b, full_b, count_b, overflow_b, underflow_b} !== 6'b100000) begin
      miscompares++;
      $display("[TB] FAIL reset_b: got e=%b f=%b c=%0d o=%b u=%b want e=1 f=0 c=0 o=0 u=0",
               empty_b, full_b, count_b, overflow_b, underflow_b);
    end
  endtask

  // Fill to full, attempt one extra write, then drain in order.
  task automatic test_fill_drain();
    logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      tick_a(1'b1, 1'b0, pat[i]);
      vectors++;
      if (count_a !== 3'(i + 1) || full_a !== (i == 3) || empty_a !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_count %0d: got c=%0d f=%b e=%b want c=%0d f=%b e=0",
                 i, count_a, full_a, empty_a, i + 1, (i == 3));
      end
      vectors++;
      if (rd_data_a !== 8'h11) begin
        miscompares++;
        $display("[TB] FAIL fill_head %0d: got %h want 11", i, rd_data_a);
      end
    end
    tick_a(1'b1, 1'b0, 8'h55);
    vectors++;
    if (overflow_a !== 1'b1 || count_a !== 3'd4 || underflow_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overflow_pulse: got o=%b c=%0d u=%b want o=1 c=4 u=0",
               overflow_a, count_a, underflow_a);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_data_a !== pat[i]) begin
        miscompares++;
        $display("[TB] FAIL drain_data %0d: got %h want %h", i, rd_data_a, pat[i]);
      end
      tick_a(1'b0, 1'b1, 8'h00);
      vectors++;
      if (count_a !== 3'(3 - i) || overflow_a !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL drain_count %0d: got c=%0d o=%b want c=%0d o=0",
                 i, count_a, overflow_a, 3 - i);
      end
    end
    vectors++;
    if (empty_a !== 1'b1 || full_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain_empty: got e=%b f=%b want e=1 f=0", empty_a, full_a);
    end
  endtask

  // Read from empty, then a write must still land at the head.
  task automatic test_underflow();
    tick_a(1'b0, 1'b1, 8'h00);
    vectors++;
    if (underflow_a !== 1'b1 || count_a !== 3'd0 || empty_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL underflow_pulse: got u=%b c=%0d e=%b want u=1 c=0 e=1",
               underflow_a, count_a, empty_a);
    end
    tick_a(1'b1, 1'b0, 8'hA5);
    vectors++;
    if (underflow_a !== 1'b0 || rd_data_a !== 8'hA5 || count_a !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL after_underflow: got u=%b d=%h c=%0d want u=0 d=a5 c=1",
               underflow_a, rd_data_a, count_a);
    end
    tick_a(1'b0, 1'b1, 8'h00);
  endtask

  // Simultaneous read and write at count 2, 0 and 4.
  task automatic test_simultaneous();
    tick_a(1'b1, 1'b0, 8'h01);
    tick_a(1'b1, 1'b0, 8'h02);
    tick_a(1'b1, 1'b1, 8'h03);
    vectors++;
    if (count_a !== 3'd2 || rd_data_a !== 8'h02 || overflow_a !== 1'b0 || underflow_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL simul_mid: got c=%0d d=%h o=%b u=%b want c=2 d=02 o=0 u=0",
               count_a, rd_data_a, overflow_a, underflow_a);
    end
    tick_a(1'b0, 1'b1, 8'h00);
    vectors++;
    if (rd_data_a !== 8'h03 || count_a !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL simul_mid_order: got d=%h c=%0d want d=03 c=1", rd_data_a, count_a);
    end
    tick_a(1'b0, 1'b1, 8'h00);

    tick_a(1'b1, 1'b1, 8'h04);
    vectors++;
    if (count_a !== 3'd1 || underflow_a !== 1'b1 || rd_data_a !== 8'h04) begin
      miscompares++;
      $display("[TB] FAIL simul_empty: got c=%0d u=%b d=%h want c=1 u=1 d=04",
               count_a, underflow_a, rd_data_a);
    end
    tick_a(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 4; i++) tick_a(1'b1, 1'b0, 8'(8'h10 + i));
    tick_a(1'b1, 1'b1, 8'h99);
    vectors++;
    if (count_a !== 3'd3 || overflow_a !== 1'b1 || full_a !== 1'b0 || rd_data_a !== 8'h11) begin
      miscompares++;
      $display("[TB] FAIL simul_full: got c=%0d o=%b f=%b d=%h want c=3 o=1 f=0 d=11",
               count_a, overflow_a, full_a, rd_data_a);
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (rd_data_a !== 8'(8'h10 + i)) begin
        miscompares++;
        $display("[TB] FAIL simul_full_drain %0d: got %h want %h", i, rd_data_a, 8'(8'h10 + i));
      end
      tick_a(1'b0, 1'b1, 8'h00);
    end
    vectors++;
    if (empty_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL simul_full_empty: got e=%b want 1", empty_a);
    end
  endtask

  // DEPTH=3 streaming: one write per cycle when there is room, a read on
  // every other cycle, until ten words have come out.
  task automatic test_wrap();
    logic [7:0] q[$];
    int         sent = 0;
    int         got  = 0;
    logic       w, r, racc, wacc;
    logic [7:0] d;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      vectors++;
      if (count_b !== 2'(q.size()) || empty_b !== (q.size() == 0) || full_b !== (q.size() == 3)) begin
        miscompares++;
        $display("[TB] FAIL wrap_status cyc %0d: got c=%0d e=%b f=%b want c=%0d",
                 cyc, count_b, empty_b, full_b, q.size());
      end
      if (q.size() > 0) begin
        vectors++;
        if (rd_data_b !== q[0]) begin
          miscompares++;
          $display("[TB] FAIL wrap_data cyc %0d: got %h want %h", cyc, rd_data_b, q[0]);
        end
      end
      w    = (sent < 10) && (q.size() < 3);
      r    = (cyc % 2 == 1);
      d    = 8'($urandom_range(0, 255));
      racc = r && (q.size() > 0);
      wacc = w;
      tick_b(w, r, d);
      if (racc) begin
        void'(q.pop_front());
        got++;
      end
      if (wacc) begin
        q.push_back(d);
        sent++;
      end
    end
    vectors++;
    if (got != 10) begin
      miscompares++;
      $display("[TB] FAIL wrap_budget: got %0d words want 10", got);
    end
    tick_b(1'b0, 1'b0, 8'h00);
  endtask

  // Reset mid-stream with both requests active.
  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) tick_a(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    rst_a = 1'b0;
    tick_a(1'b1, 1'b1, 8'hEE);
    rst_a = 1'b1;
    vectors++;
    if (count_a !== 3'd0 || empty_a !== 1'b1 || overflow_a !== 1'b0 || underflow_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got c=%0d e=%b o=%b u=%b want c=0 e=1 o=0 u=0",
               count_a, empty_a, overflow_a, underflow_a);
    end
    tick_a(1'b1, 1'b0, 8'h7E);
    vectors++;
    if (rd_data_a !== 8'h7E || count_a !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_write: got d=%h c=%0d want d=7e c=1", rd_data_a, count_a);
    end
    tick_a(1'b0, 1'b1, 8'h00);
  endtask

  // Random traffic against a queue model, checked every cycle.
  task automatic test_soak();
    logic [7:0] q[$];
    logic       w, r, wacc, racc, exp_ovf, exp_unf;
    logic [7:0] d;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      w       = 1'($urandom_range(0, 1));
      r       = 1'($urandom_range(0, 1));
      d       = 8'($urandom_range(0, 255));
      wacc    = w && (q.size() < 4);
      racc    = r && (q.size() > 0);
      exp_ovf = w && !wacc;
      exp_unf = r && !racc;
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
      tick_a(w, r, d);
      vectors++;
      if (count_a !== 3'(q.size()) || full_a !== (q.size() == 4) || empty_a !== (q.size() == 0)
          || overflow_a !== exp_ovf || underflow_a !== exp_unf) begin
        miscompares++;
        $display("[TB] FAIL soak_status cyc %0d: got c=%0d f=%b e=%b o=%b u=%b want c=%0d o=%b u=%b",
                 cyc, count_a, full_a, empty_a, overflow_a, underflow_a, q.size(), exp_ovf, exp_unf);
      end
      if (q.size() > 0) begin
        vectors++;
        if (rd_data_a !== q[0]) begin
          miscompares++;
          $display("[TB] FAIL soak_data cyc %0d: got %h want %h", cyc, rd_data_a, q[0]);
        end
      end
    end
  endtask

  // Scenario sequence; the summary line closes the run.
  initial begin
    wr_en_a = 1'b0; rd_en_a = 1'b0; wr_data_a = 8'h00; rst_a = 1'b0;
    wr_en_b = 1'b0; rd_en_b = 1'b0; wr_data_b = 8'h00; rst_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_fifo

// File: doc/reg_fifo.md
Name: reg_fifo

Overview:
Synchronous first-word-fall-through (FWFT) FIFO built from a register array. It sits directly downstream of a producer register stage and buffers its words for a consumer that cannot accept data every cycle. It has one clock domain and carries data only; it adds no framing.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2; need not be a power of two)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, ACTIVE-LOW; sampled on rising clk edge
wr_en  input  1  write request
wr_data  input  WIDTH  word to write
rd_en  input  1  read (pop) request
rd_data  output  WIDTH  head-of-queue word; valid whenever empty=0
full  output  1  1 when count==DEPTH
empty  output  1  1 when count==0
count  output  $clog2(DEPTH+1)  number of stored words
overflow  output  1  one-cycle pulse: write attempted while full, data dropped
underflow  output  1  one-cycle pulse: read attempted while empty, ignored

Behaviour:
- Reset (rst==0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, overflow=0, underflow=0.
  - Storage contents are don't-care.
  - Reset overrides any simultaneous wr_en/rd_en.
  - A mid-operation reset discards all stored words and is effective the very next cycle.
- Accept rules, evaluated at posedge:
  - wr_accept = wr_en && !full.
  - rd_accept = rd_en && !empty.
  - full and empty are the registered-state values from before the edge.
- Write: when wr_accept, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Read: when rd_accept, rd_ptr advances.
- Pointer wrap: ptr==DEPTH-1 goes to 0. Use explicit compare, not modulo-2^n, so non-power-of-2 DEPTH works.
- count next-state:
  - +1 if wr_accept && !rd_accept.
  - -1 if rd_accept && !wr_accept.
  - Otherwise unchanged.
- full and empty are derived from count: full=(count==DEPTH), empty=(count==0). They update in the same cycle count changes.
- rd_data:
  - Combinational mem[rd_ptr] (FWFT).
  - A word written into an empty FIFO appears on rd_data one cycle after the write edge, with empty=0 in that same cycle.
  - Write-to-read latency is 1 cycle.
  - rd_data is don't-care while empty=1.
- Simultaneous wr_en && rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: write accepted, read rejected (underflow=1 next cycle), count becomes 1.
  - Full: read accepted, write rejected (overflow=1 next cycle), count becomes DEPTH-1.
  - A full FIFO never accepts a write in the same cycle it pops.
- overflow and underflow:
  - Registered. Asserted for exactly the cycle after the offending edge.
  - Not sticky; cleared by the next edge unless the condition repeats.
- Ordering: strict FIFO. A rejected write never corrupts storage or pointers.
- No X propagation: every output except rd_data is defined from reset onward.

Decomposition:
- Package fifo_pkg holds:
  - function next_ptr(ptr, depth), giving wrap-around increment.
  - localparam helpers ADDR_W=$clog2(DEPTH) and CNT_W=$clog2(DEPTH+1), as functions of DEPTH.
- One natural sub-module, reg_fifo_mem:
  - WIDTH x DEPTH register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset on the array.
- Control logic (pointers, count, flags, error pulses) stays in reg_fifo.

Test Plan:
1. DEPTH=4, WIDTH=8. Hold rst=0 for 5 cycles, release on negedge -> empty=1, full=0, count=0, overflow=underflow=0 every cycle.
2. Write 0x11,0x22,0x33,0x44 on consecutive cycles, no reads:
   - count goes 1,2,3,4.
   - full=1 after the 4th edge.
   - rd_data=0x11 from the cycle after the first write.
   - Then write 0x55 -> overflow=1 for one cycle, count stays 4.
   - Drain 4 reads -> 0x11,0x22,0x33,0x44 in order, empty=1.
3. Empty FIFO, rd_en=1 alone -> underflow=1 next cycle, count=0, pointers unchanged. Next write of 0xA5 -> rd_data=0xA5.
4. Simultaneous rd_en and wr_en:
   - At count=2: count stays 2, order preserved.
   - At count=0: count=1, underflow pulse.
   - At count=4: count=3, overflow pulse, dropped word never appears.
5. Wrap-around, DEPTH=3 (non-power-of-2): stream 10 words with interleaved single reads -> output sequence equals input sequence and pointers wrap 2->0.
6. With count=3, assert rst=0 for one cycle during simultaneous rd/wr -> next cycle count=0, empty=1. A subsequent write of 0x7E reads back 0x7E.
7. Random soak, 10000 cycles, $urandom wr_en/rd_en/wr_data -> matches a scoreboard queue model on every cycle for rd_data (when !empty), count, full, empty, overflow and underflow.
